// File: rtl/integrate_and_dump.sv
// Integrate-and-dump: sums a signed sample stream over PERIOD-clock windows framed by sync.
// Optional saturating arithmetic with overflow flag when INTEGRATE_AND_DUMP_SAT_EN is defined.
module integrate_and_dump #(
   parameter int WIDTH     = 18,
   parameter int OUT_WIDTH = 32,
   parameter int PERIOD    = 128
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        sync,
   input  logic                        en,
   input  logic signed [WIDTH-1:0]     din,
   output logic signed [OUT_WIDTH-1:0] dout,
   output logic                        dout_valid,
   output logic                        sync_out,
   output logic                        overflow
);

   localparam int CTR_W = $clog2(PERIOD);
   localparam logic [CTR_W-1:0] LAST = CTR_W'(PERIOD - 1);

   logic [CTR_W-1:0]            ctr;
   logic signed [OUT_WIDTH-1:0] acc;
   logic signed [OUT_WIDTH-1:0] x;
   logic signed [OUT_WIDTH-1:0] sum;
   logic                        last;

   // Size cast of a signed operand sign-extends din to the accumulator width.
   assign x    = en ? OUT_WIDTH'(din) : '0;
   assign last = (ctr == LAST);

`ifdef INTEGRATE_AND_DUMP_SAT_EN
   localparam logic [OUT_WIDTH-1:0] SAT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
   localparam logic [OUT_WIDTH-1:0] SAT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

   logic [OUT_WIDTH:0] wide;
   logic               sat;
   logic               sticky;

   // One guard bit: the add overflowed when the two top bits disagree.
   assign wide = {acc[OUT_WIDTH-1], acc} + {x[OUT_WIDTH-1], x};
   assign sat  = wide[OUT_WIDTH] ^ wide[OUT_WIDTH-1];
   assign sum  = !sat            ? signed'(wide[OUT_WIDTH-1:0]) :
                 wide[OUT_WIDTH] ? signed'(SAT_MIN) : signed'(SAT_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky   <= 1'b0;
         overflow <= 1'b0;
      end else if (sync) begin
         sticky <= 1'b0;
      end else if (last) begin
         overflow <= sticky | sat;
         sticky   <= 1'b0;
      end else begin
         sticky <= sticky | sat;
      end
   end
`else
   assign sum      = acc + x;
   assign overflow = 1'b0;
`endif

   // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctr        <= '0;
         acc        <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         sync_out   <= 1'b0;
      end else begin
         sync_out <= sync;
         if (sync) begin
            // Restart wins over a dump; the partial window and this sample are dropped.
            ctr        <= '0;
            acc        <= '0;
            dout_valid <= 1'b0;
         end else if (last) begin
            ctr        <= '0;
            acc        <= '0;
            dout       <= sum;
            dout_valid <= 1'b1;
         end else begin
            ctr        <= ctr + CTR_W'(1);
            acc        <= sum;
            dout_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_integrate_and_dump.sv
// Self-checking bench for integrate_and_dump: queue-based window model, randomized and directed scenarios.
// A second small instance exercises wrap/saturation (INTEGRATE_AND_DUMP_SAT_EN selects expectations).
module tb_integrate_and_dump;

   localparam int W  = 18;
   localparam int OW = 32;
   localparam int P  = 8;
   localparam int SW = 8;
   localparam int SP = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic                 sync = 1'b0, en = 1'b0;
   logic signed [W-1:0]  din = '0;
   logic signed [OW-1:0] dout;
   logic                 dout_valid, sync_out, overflow;

   logic                 sync2 = 1'b0, en2 = 1'b0;
   logic signed [SW-1:0] din2 = '0;
   logic signed [SW-1:0] dout2;
   logic                 dout_valid2, sync_out2, overflow2;

   integrate_and_dump #(.WIDTH(W), .OUT_WIDTH(OW), .PERIOD(P)) dut (
      .clk(clk), .rst_n(rst_n), .sync(sync), .en(en), .din(din),
      .dout(dout), .dout_valid(dout_valid), .sync_out(sync_out), .overflow(overflow));

   integrate_and_dump #(.WIDTH(SW), .OUT_WIDTH(SW), .PERIOD(SP)) dut_small (
      .clk(clk), .rst_n(rst_n), .sync(sync2), .en(en2), .din(din2),
      .dout(dout2), .dout_valid(dout_valid2), .sync_out(sync_out2), .overflow(overflow2));

   int checks = 0;
   int errors = 0;

   // Reference model: samples of the current window and the last published result.
   int                   win[$];
   logic signed [OW-1:0] exp_dout = '0;
   bit                   exp_valid = 1'b0, exp_sync_out = 1'b0, exp_ovf = 1'b0;

   // Window sum from the list of samples, with the arithmetic the build selects.
   function automatic void fold(input int q[$], input int ow, output longint val, output bit ovf);
      longint hi, lo, m, s;
      hi  = (longint'(1) <<< (ow - 1)) - 1;
      lo  = -hi - 1;
      m   = longint'(1) <<< ow;
      s   = 0;
      ovf = 1'b0;
      foreach (q[i]) begin
         s += q[i];
`ifdef INTEGRATE_AND_DUMP_SAT_EN
         if (s > hi) begin s = hi; ovf = 1'b1; end
         else if (s < lo) begin s = lo; ovf = 1'b1; end
`endif
      end
`ifndef INTEGRATE_AND_DUMP_SAT_EN
      s = s % m;
      if (s > hi) s -= m;
      else if (s < lo) s += m;
`endif
      val = s;
   endfunction

   task automatic model_reset();
      win.delete();
      exp_dout     = '0;
      exp_valid    = 1'b0;
      exp_sync_out = 1'b0;
      exp_ovf      = 1'b0;
   endtask

   // Apply one cycle of main-DUT inputs, advance the model across the edge, sample 1 ns later.
   task automatic drive_cycle(input bit s, input bit e, input int d);
      longint v;
      bit     o;
      sync = s;
      en   = e;
      din  = W'(d);
      @(posedge clk);
      exp_sync_out = s;
      if (s) begin
         win.delete();
         exp_valid = 1'b0;
      end else begin
         win.push_back(e ? d : 0);
         if (win.size() == P) begin
            fold(win, OW, v, o);
            exp_dout  = OW'(v);
            exp_ovf   = o;
            exp_valid = 1'b1;
            win.delete();
         end else begin
            exp_valid = 1'b0;
         end
      end
      #1;
   endtask

   function automatic int rand_sample();
      return int'($urandom_range(0, (1 << W) - 1)) - (1 << (W - 1));
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      #2;
      checks++;
      if (dout !== '0 || dout_valid !== 1'b0 || sync_out !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_main dout=%0d valid=%b sync_out=%b ovf=%b expected all 0",
                  dout, dout_valid, sync_out, overflow);
      end
      checks++;
      if (dout2 !== '0 || dout_valid2 !== 1'b0 || overflow2 !== 1'b0) begin
         errors++;
         $display("FAIL reset_small dout=%0d valid=%b ovf=%b expected all 0", dout2, dout_valid2, overflow2);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_constant();
      for (int i = 0; i < 3 * P; i++) begin
         drive_cycle(1'b0, 1'b1, 1);
         checks++;
         if (dout_valid !== exp_valid || dout !== exp_dout) begin
            errors++;
            $display("FAIL const_model[%0d] valid=%b dout=%0d expected valid=%b dout=%0d",
                     i, dout_valid, dout, exp_valid, exp_dout);
         end
         checks++;
         if (dout_valid !== (i % P == P - 1) || (dout_valid === 1'b1 && dout !== OW'(P))) begin
            errors++;
            $display("FAIL const_timing[%0d] valid=%b dout=%0d expected valid=%b dout=%0d",
                     i, dout_valid, dout, (i % P == P - 1), P);
         end
      end
   endtask

   task automatic test_negative();
      drive_cycle(1'b1, 1'b0, 0);
      for (int i = 0; i < P; i++) drive_cycle(1'b0, 1'b1, -3);
      checks++;
      if (dout_valid !== 1'b1 || dout !== 32'hFFFF_FFE8 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL negative valid=%b dout=%h ovf=%b expected valid=1 dout=ffffffe8 ovf=0",
                  dout_valid, dout, overflow);
      end
   endtask

   task automatic test_en_toggle();
      drive_cycle(1'b1, 1'b0, 0);
      for (int i = 0; i < P; i++) drive_cycle(1'b0, (i % 2) == 0, 5);
      checks++;
      if (dout_valid !== 1'b1 || dout !== 32'sd20 || dout !== exp_dout) begin
         errors++;
         $display("FAIL en_toggle valid=%b dout=%0d expected valid=1 dout=20", dout_valid, dout);
      end
   endtask

   task automatic test_sync_mid();
      logic signed [OW-1:0] held;
      drive_cycle(1'b1, 1'b0, 0);
      for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b1, rand_sample());
      held = dout;
      drive_cycle(1'b1, 1'b1, 7);
      checks++;
      if (dout_valid !== 1'b0 || sync_out !== 1'b1 || dout !== held) begin
         errors++;
         $display("FAIL sync_mid valid=%b sync_out=%b dout=%0d expected valid=0 sync_out=1 dout=%0d",
                  dout_valid, sync_out, dout, held);
      end
      for (int i = 0; i < P; i++) begin
         drive_cycle(1'b0, 1'b1, rand_sample());
         checks++;
         if (dout_valid !== (i == P - 1) || dout !== exp_dout || sync_out !== 1'b0) begin
            errors++;
            $display("FAIL sync_mid_refill[%0d] valid=%b dout=%0d sync_out=%b expected valid=%b dout=%0d sync_out=0",
                     i, dout_valid, dout, sync_out, (i == P - 1), exp_dout);
         end
      end
      for (int i = 0; i < P - 1; i++) drive_cycle(1'b0, 1'b1, 9);
      held = dout;
      drive_cycle(1'b1, 1'b1, 9);
      checks++;
      if (dout_valid !== 1'b0 || dout !== held) begin
         errors++;
         $display("FAIL sync_last valid=%b dout=%0d expected valid=0 dout=%0d", dout_valid, dout, held);
      end
   endtask

   task automatic test_back_to_back();
      logic signed [OW-1:0] dumped;
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b1, 1'b1, 11);
         checks++;
         if (dout_valid !== 1'b0 || sync_out !== 1'b1) begin
            errors++;
            $display("FAIL b2b_sync[%0d] valid=%b sync_out=%b expected valid=0 sync_out=1", i, dout_valid, sync_out);
         end
      end
      for (int i = 0; i < P; i++) drive_cycle(1'b0, 1'b1, rand_sample());
      dumped = exp_dout;
      checks++;
      if (dout_valid !== 1'b1 || dout !== dumped) begin
         errors++;
         $display("FAIL b2b_dump valid=%b dout=%0d expected valid=1 dout=%0d", dout_valid, dout, dumped);
      end
      drive_cycle(1'b1, 1'b1, 3);
      checks++;
      if (dout_valid !== 1'b0 || dout !== dumped) begin
         errors++;
         $display("FAIL sync_after_dump valid=%b dout=%0d expected valid=0 dout=%0d", dout_valid, dout, dumped);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 16 * P; i++) begin
         drive_cycle($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, rand_sample());
         checks++;
         if (dout_valid !== exp_valid || dout !== exp_dout || sync_out !== exp_sync_out || overflow !== exp_ovf) begin
            errors++;
            $display("FAIL random[%0d] valid=%b dout=%0d sync_out=%b ovf=%b expected valid=%b dout=%0d sync_out=%b ovf=%b",
                     i, dout_valid, dout, sync_out, overflow, exp_valid, exp_dout, exp_sync_out, exp_ovf);
         end
      end
   endtask

   task automatic test_async_reset();
      drive_cycle(1'b1, 1'b0, 0);
      for (int i = 0; i < P; i++) drive_cycle(1'b0, 1'b1, 2);
      for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 1000);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (dout !== '0 || dout_valid !== 1'b0 || sync_out !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL async_reset dout=%0d valid=%b sync_out=%b ovf=%b expected all 0",
                  dout, dout_valid, sync_out, overflow);
      end
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < P; i++) begin
         drive_cycle(1'b0, 1'b1, 1);
         checks++;
         if (dout_valid !== (i == P - 1) || (i == P - 1 && dout !== OW'(P)) || dout !== exp_dout) begin
            errors++;
            $display("FAIL after_reset[%0d] valid=%b dout=%0d expected valid=%b dout=%0d",
                     i, dout_valid, dout, (i == P - 1), exp_dout);
         end
      end
   endtask

   task automatic run_small(input int d);
      int     q[$];
      longint v;
      bit     o;
      q = {};
      for (int i = 0; i < SP; i++) q.push_back(d);
      fold(q, SW, v, o);
      sync2 = 1'b1;
      en2   = 1'b1;
      din2  = SW'(d);
      drive_cycle(1'b0, 1'b0, 0);
      checks++;
      if (sync_out2 !== 1'b1 || dout_valid2 !== 1'b0) begin
         errors++;
         $display("FAIL small_sync sync_out=%b valid=%b expected sync_out=1 valid=0", sync_out2, dout_valid2);
      end
      sync2 = 1'b0;
      for (int i = 0; i < SP; i++) drive_cycle(1'b0, 1'b0, 0);
      checks++;
      if (dout_valid2 !== 1'b1 || dout2 !== SW'(v) || overflow2 !== o) begin
         errors++;
         $display("FAIL small_din%0d valid=%b dout=%0d ovf=%b expected valid=1 dout=%0d ovf=%b",
                  d, dout_valid2, dout2, overflow2, v, o);
      end
      drive_cycle(1'b0, 1'b0, 0);
      checks++;
      if (dout_valid2 !== 1'b0 || dout2 !== SW'(v) || overflow2 !== o) begin
         errors++;
         $display("FAIL small_hold%0d valid=%b dout=%0d ovf=%b expected valid=0 dout=%0d ovf=%b",
                  d, dout_valid2, dout2, overflow2, v, o);
      end
   endtask

   task automatic test_saturation();
      run_small(100);
      run_small(-100);
      run_small(20);
      en2 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_constant();
      test_negative();
      test_en_toggle();
      test_sync_mid();
      test_back_to_back();
      test_random();
      test_async_reset();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/integrate_and_dump.md
Name: integrate_and_dump

Overview:
- Upstream feeder for the periodic sample-and-hold stage.
- Integrates a signed input stream over fixed windows of PERIOD clocks, restarts the window on sync, and presents each window sum with a one-cycle valid pulse.
- The downstream sample-and-hold, sharing the same sync and PERIOD, captures the dumped sum.
- Window framing is identical to that stage's counter: reset on sync, wrap at PERIOD-1.

Parameters:
- WIDTH, 18, input sample width (signed two's complement).
- OUT_WIDTH, 32, accumulator/output width (signed); must be >= WIDTH.
- PERIOD, 128, integration window length in clocks; must be >= 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sync  input  1  window restart pulse, same timing as the downstream stage's sync.
- en  input  1  sample-valid qualifier; en=0 contributes zero to the sum.
- din  input  WIDTH  signed sample.
- dout  output  OUT_WIDTH  signed window sum, held between dumps.
- dout_valid  output  1  one-cycle pulse, dout updated this cycle.
- sync_out  output  1  sync delayed 1 clock, aligned with dout timing.
- overflow  output  1  window-sum overflow flag, qualified by dout_valid.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - ctr=0, acc=0, dout=0, dout_valid=0, sync_out=0, overflow=0.
  - Reset asserted mid-window discards the partial sum.
  - After release, the first window starts at ctr=0 with no sync needed.
- Counter: ctr is clog2(PERIOD) bits.
  - If sync: ctr<=0.
  - Else if ctr==PERIOD-1: ctr<=0.
  - Else: ctr<=ctr+1.
- Sample term: x = en ? sign_extend(din, OUT_WIDTH) : 0.
- Sync cycle:
  - acc<=0, and x from this cycle is discarded.
  - No dump occurs, so dout_valid stays 0 and dout holds.
  - Sync takes priority even when ctr==PERIOD-1; the partial window is dropped.
- Dump cycle (ctr==PERIOD-1 and !sync):
  - dout<=acc+x; dout_valid<=1 for exactly one clock; acc<=0.
  - The window is ctr=0..PERIOD-1, i.e. PERIOD samples.
- Other cycles: acc<=acc+x; dout_valid<=0.
- Latency: the window sum appears on dout one clock after the window's last sample.
  - dout is stable for PERIOD-1 clocks after each dump; the downstream hold latches it.
- sync_out<=sync every clock.
- Arithmetic: full OUT_WIDTH signed add. Overflow handling is set by the optional feature.
- Back-to-back syncs: each one re-clears acc and ctr, and no dump occurs.
- A sync one clock after a dump is legal; dout retains the dumped value.

Optional Feature:
- Macro INTEGRATE_AND_DUMP_SAT_EN.
- When defined:
  - Every add saturates to the signed OUT_WIDTH limits, +(2^(OUT_WIDTH-1)-1) or -2^(OUT_WIDTH-1).
  - An internal sticky flag sets on any saturating add within the window.
  - At dump, overflow<=sticky flag (including the dump-cycle add), then the flag clears.
  - Sync and reset also clear the flag.
  - overflow holds with dout until the next dump.
- When undefined:
  - Two's complement wrap-around.
  - overflow is tied 0 and no saturation logic is built.

Test Plan:
- Reset then en=1, din=1, no sync, PERIOD=8:
  - dout_valid pulses at clocks 9, 17, 25... after release.
  - dout=8 each time; dout=0 before the first pulse.
- din=-3 with en=1 for a full window, PERIOD=8 -> dout=-24 (0xFFFFFFE8 at OUT_WIDTH=32), overflow=0.
- en toggling 1,0,1,0..., din=5, PERIOD=8 -> dout=20.
- Sync asserted at ctr=5 mid-window:
  - No dout_valid; sync_out pulses 1 clock later.
  - The next dump arrives PERIOD+1 clocks after sync with the full-window sum.
  - Sync at ctr==PERIOD-1 produces no dump.
- OUT_WIDTH=WIDTH=8, PERIOD=4, din=100, en=1:
  - With SAT_EN: dout=127, overflow=1.
  - Without: dout=-112 (400 mod 256 signed), overflow=0.
- rst_n pulled low at ctr=3 for 1 clock -> all outputs 0 immediately (async); the first dump occurs PERIOD clocks after release, with no partial sum carried over.
